fifo_to_mem: RTL and testbench
==============================

Name: fifo_to_mem

Overview:
- Record-side counterpart of the replay path: drains captured packet words from a first-word-fall-through (FWFT) FIFO and writes them sequentially into external SRAM.
- Writes start at MEM_ADDR_LOW.
- Publishes the final written address as q0_mem_high, which the replay reader uses as its upper bound.
- Sits between the capture FIFO and the memory controller write port.

Parameters:
- FIFO_DATA_WIDTH, 144, width of FIFO words.
- MEM_ADDR_WIDTH, 19, memory word-address width.
- MEM_DATA_WIDTH, 144, memory write data width; must equal FIFO_DATA_WIDTH.
- MEM_BW_WIDTH, 4, byte-write-enable width; always driven all-ones.
- MEM_ADDR_LOW, 0, first address written.
- REPLAY_COUNT_WIDTH, 32, width of the optional word counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- fifo_dout  in  FIFO_DATA_WIDTH  FWFT data; valid whenever fifo_empty=0.
- fifo_empty  in  1  FIFO empty.
- fifo_rd_en  out  1  pop; combinational, asserted only when fifo_empty=0.
- app_wr_cmd  out  1  write command valid (registered).
- app_wr_addr  out  MEM_ADDR_WIDTH  write address (registered).
- app_wr_data  out  MEM_DATA_WIDTH  write data (registered).
- app_wr_bw  out  MEM_BW_WIDTH  byte enables; constant all-ones.
- app_wr_rdy  in  1  controller accepts command when app_wr_cmd=1 and app_wr_rdy=1.
- cal_done  in  1  memory calibration complete.
- start_store  in  1  one-cycle pulse; begins a new recording.
- stop_store  in  1  level/pulse; finish after FIFO drains.
- sw_rst  in  1  synchronous soft reset; same effect as rst.
- store_busy  out  1  high from start until DONE.
- store_done  out  1  high in DONE until next start_store or reset.
- mem_addr_high  out  1  sticky; memory region exhausted.
- q0_mem_high  out  MEM_ADDR_WIDTH  last address written; valid when store_done=1.

Behaviour:
- Reset (rst=0 or sw_rst=1) values:
  - all outputs 0, except app_wr_bw = all-ones and q0_mem_high = MEM_ADDR_LOW.
  - state = IDLE; internal address counter = MEM_ADDR_LOW.
  - stop latch cleared.
- Reset mid-burst: any pending command is dropped without handshake.
- States:
  - IDLE: start_store -> WAIT_CAL.
  - WAIT_CAL: cal_done=1 -> WRITE. Address counter = MEM_ADDR_LOW; mem_addr_high, store_done and stop latch cleared.
  - WRITE: transfer loop, below.
  - FLUSH: wait for the output register to drain.
  - DONE: store_done=1; start_store -> WAIT_CAL.
- Output register: one entry (app_wr_cmd/app_wr_addr/app_wr_data).
  - Reloadable when app_wr_cmd=0, or when the handshake completes in the same cycle.
- In WRITE, fifo_rd_en = !fifo_empty & reloadable & !full_flag.
  - On a pop, next cycle: app_wr_cmd=1, app_wr_data=fifo_dout, app_wr_addr=counter; counter increments.
  - Latency is 1 cycle from pop to command visible.
  - With app_wr_rdy held at 1, throughput is 1 word/cycle.
- app_wr_cmd/addr/data hold stable while app_wr_cmd=1 and app_wr_rdy=0.
- Handshake with no new pop: app_wr_cmd drops to 0 next cycle.
- stop_store is latched on any cycle in WRITE.
  - When latched, fifo_empty=1 and no pop this cycle -> FLUSH.
  - A simultaneous pop is written first.
- full_flag:
  - Set when a word is popped while the counter equals all-ones (2^MEM_ADDR_WIDTH-1).
  - The counter does not wrap; no further pops.
  - mem_addr_high=1 (sticky until next start); state -> FLUSH.
- FLUSH -> DONE once app_wr_cmd=0.
  - q0_mem_high = address of the last accepted write, or MEM_ADDR_LOW if zero words were written.
- start_store outside IDLE/DONE is ignored.
- stop_store in IDLE/WAIT_CAL is latched and takes effect on entry to WRITE, giving a zero-length record if the FIFO is empty.
- cal_done falling during WRITE: no effect; the controller gates via app_wr_rdy.
- store_busy = state is WAIT_CAL, WRITE or FLUSH.

Optional Feature:
- STORE_WORD_COUNT_EN defined:
  - Adds output stored_words [REPLAY_COUNT_WIDTH-1:0].
  - Cleared on reset/start; increments on each accepted write handshake; saturates at all-ones.
- Undefined: port and counter absent; remaining behaviour identical.

Test Plan:
- Basic store:
  - Stimulus: cal_done=1, start_store, FIFO holds 8 words 0x1..0x8, app_wr_rdy=1, stop_store after the FIFO empties.
  - Response: 8 writes to addresses 0..7, data 0x1..0x8, back-to-back cycles; q0_mem_high=7; store_done=1; stored_words=8 if STORE_WORD_COUNT_EN.
- Backpressure:
  - Stimulus: app_wr_rdy toggles 1,0,0,1 during a 4-word store.
  - Response: addr/data stable while rdy=0; no drops or duplicates; 4 accepted writes total.
- Calibration gate:
  - Stimulus: start_store with cal_done=0 for 50 cycles, FIFO non-empty.
  - Response: no fifo_rd_en or app_wr_cmd until cal_done rises; then writes begin at MEM_ADDR_LOW.
- Address exhaustion:
  - Stimulus: MEM_ADDR_WIDTH=4, 20 words queued.
  - Response: exactly 16 writes (0..15); mem_addr_high=1; q0_mem_high=15; 4 words left in FIFO.
- Reset mid-operation:
  - Stimulus: rst low for 1 cycle after 3 writes with app_wr_cmd pending and rdy=0.
  - Response: all outputs at reset values immediately; state IDLE; next start_store restarts at address 0.
- Zero-length record:
  - Stimulus: stop_store with an empty FIFO, then start_store.
  - Response: no writes; store_done=1; q0_mem_high=MEM_ADDR_LOW.

Source files
------------

// File: rtl/fifo_to_mem.sv
// Drains an FWFT capture FIFO into SRAM through a one-entry registered write port.
// Optional STORE_WORD_COUNT_EN adds a saturating count of accepted writes (stored_words).
module fifo_to_mem #(
  parameter int FIFO_DATA_WIDTH    = 144,
  parameter int MEM_ADDR_WIDTH     = 19,
  parameter int MEM_DATA_WIDTH     = 144,
  parameter int MEM_BW_WIDTH       = 4,
  parameter int MEM_ADDR_LOW       = 0,
  parameter int REPLAY_COUNT_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [FIFO_DATA_WIDTH-1:0]    fifo_dout,
  input  logic                          fifo_empty,
  output logic                          fifo_rd_en,
  output logic                          app_wr_cmd,
  output logic [MEM_ADDR_WIDTH-1:0]     app_wr_addr,
  output logic [MEM_DATA_WIDTH-1:0]     app_wr_data,
  output logic [MEM_BW_WIDTH-1:0]       app_wr_bw,
  input  logic                          app_wr_rdy,
  input  logic                          cal_done,
  input  logic                          start_store,
  input  logic                          stop_store,
  input  logic                          sw_rst,
  output logic                          store_busy,
  output logic                          store_done,
  output logic                          mem_addr_high,
  output logic [MEM_ADDR_WIDTH-1:0]     q0_mem_high,
`ifdef STORE_WORD_COUNT_EN
  output logic [REPLAY_COUNT_WIDTH-1:0] stored_words,
`endif
  output logic [2:0]                    state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_CAL = 3'd1,
    S_WRITE    = 3'd2,
    S_FLUSH    = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_LOW = MEM_ADDR_LOW[MEM_ADDR_WIDTH-1:0];
  localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_MAX = '1;

  state_t                    state, next_state;
  logic [MEM_ADDR_WIDTH-1:0] addr_cnt;
  logic                      full_flag;
  logic                      stop_latch;
  logic                      reloadable, accept, stop_eff, at_top, rec_begin;

  // Write port handshake: a command is accepted on any rising edge where
  // app_wr_cmd and app_wr_rdy are both high; until then addr/data hold.
  assign reloadable = !app_wr_cmd || app_wr_rdy;
  assign accept     = app_wr_cmd && app_wr_rdy;
  assign stop_eff   = stop_latch || stop_store;
  assign at_top     = (addr_cnt == ADDR_MAX);
  assign rec_begin  = (state == S_WAIT_CAL) && cal_done;
  assign fifo_rd_en = (state == S_WRITE) && !fifo_empty && reloadable && !full_flag;

  assign app_wr_bw  = '1;
  assign store_busy = (state == S_WAIT_CAL) || (state == S_WRITE) || (state == S_FLUSH);
  assign store_done = (state == S_DONE);
  assign state_dbg  = state;

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:     if (start_store) next_state = S_WAIT_CAL;
      S_WAIT_CAL: if (cal_done) next_state = S_WAIT_CAL == state ? S_WRITE : state;
      S_WRITE: begin
        // A pop that lands on the top address ends the record; otherwise a
        // pending stop ends it only once the FIFO has nothing left to pop.
        if (fifo_rd_en && at_top)
          next_state = S_FLUSH;
        else if (stop_eff && fifo_empty && !fifo_rd_en)
          next_state = S_FLUSH;
      end
      S_FLUSH:    if (!app_wr_cmd) next_state = S_DONE;
      S_DONE:     if (start_store) next_state = S_WAIT_CAL;
      default:    next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        state <= S_IDLE;
    else if (sw_rst) state <= S_IDLE;
    else             state <= next_state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_cnt      <= ADDR_LOW;
      full_flag     <= 1'b0;
      mem_addr_high <= 1'b0;
      q0_mem_high   <= ADDR_LOW;
      stop_latch    <= 1'b0;
      app_wr_cmd    <= 1'b0;
      app_wr_addr   <= '0;
      app_wr_data   <= '0;
    end else if (sw_rst) begin
      addr_cnt      <= ADDR_LOW;
      full_flag     <= 1'b0;
      mem_addr_high <= 1'b0;
      q0_mem_high   <= ADDR_LOW;
      stop_latch    <= 1'b0;
      app_wr_cmd    <= 1'b0;
      app_wr_addr   <= '0;
      app_wr_data   <= '0;
    end else begin
      if (rec_begin) begin
        addr_cnt      <= ADDR_LOW;
        full_flag     <= 1'b0;
        mem_addr_high <= 1'b0;
        q0_mem_high   <= ADDR_LOW;
      end
      // A stop seen before the record starts is kept so it applies on entry to WRITE.
      if (state == S_WRITE && next_state != S_WRITE)
        stop_latch <= 1'b0;
      else if (stop_store && (state == S_IDLE || state == S_WAIT_CAL || state == S_WRITE))
        stop_latch <= 1'b1;
      if (fifo_rd_en) begin
        app_wr_cmd  <= 1'b1;
        app_wr_addr <= addr_cnt;
        app_wr_data <= fifo_dout;
        if (at_top) begin
          full_flag     <= 1'b1;
          mem_addr_high <= 1'b1;
        end else begin
          addr_cnt <= addr_cnt + 1'b1;
        end
      end else if (accept) begin
        app_wr_cmd <= 1'b0;
      end
      if (accept)
        q0_mem_high <= app_wr_addr;
    end
  end

`ifdef STORE_WORD_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stored_words <= '0;
    else if (sw_rst)
      stored_words <= '0;
    else if (start_store && (state == S_IDLE || state == S_DONE))
      stored_words <= '0;
    else if (accept && stored_words != '1)
      stored_words <= stored_words + 1'b1;
  end
`endif

endmodule

// File: tb/tb_fifo_to_mem.sv
// Directed/randomized bench for fifo_to_mem with a queue-based FIFO and memory-write model.
module tb_fifo_to_mem;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic          app_wr_cmd;
  logic [AW-1:0] app_wr_addr;
  logic [DW-1:0] app_wr_data;
  logic [BW-1:0] app_wr_bw;
  logic          app_wr_rdy = 1'b0;
  logic          cal_done = 1'b0;
  logic          start_store = 1'b0;
  logic          stop_store = 1'b0;
  logic          sw_rst = 1'b0;
  logic          store_busy, store_done, mem_addr_high;
  logic [AW-1:0] q0_mem_high;
`ifdef STORE_WORD_COUNT_EN
  logic [31:0]   stored_words;
`endif
  logic [2:0]    state_dbg;

  fifo_to_mem #(
    .FIFO_DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW),
    .MEM_BW_WIDTH(BW), .MEM_ADDR_LOW(0), .REPLAY_COUNT_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .app_wr_cmd(app_wr_cmd), .app_wr_addr(app_wr_addr),
    .app_wr_data(app_wr_data), .app_wr_bw(app_wr_bw), .app_wr_rdy(app_wr_rdy),
    .cal_done(cal_done), .start_store(start_store), .stop_store(stop_store),
    .sw_rst(sw_rst), .store_busy(store_busy), .store_done(store_done),
    .mem_addr_high(mem_addr_high), .q0_mem_high(q0_mem_high),
`ifdef STORE_WORD_COUNT_EN
    .stored_words(stored_words),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            exp_addr;
  int            rd_ptr = 0;
  int            pops_done = 0;
  int            rdy_mode = 0;
  int            pat_idx = 0;
  logic [3:0]    rdy_pat = 4'b1001;

  // observations recorded on the falling edge, read only by the main sequence
  logic [AW-1:0] obs_addr_q[$];
  logic [DW-1:0] obs_data_q[$];
  longint        obs_t_q[$];
  int            n_pops = 0;
  int            n_cmd_seen = 0;
  int            hold_cnt = 0;
  int            hold_bad = 0;
  logic          prev_stall = 1'b0;
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_data;

  always @(negedge clk) begin
    if (fifo_rd_en) n_pops++;
    if (!rst || sw_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (app_wr_cmd) n_cmd_seen++;
      if (prev_stall) begin
        hold_cnt++;
        if (!app_wr_cmd || app_wr_addr !== hold_addr || app_wr_data !== hold_data) hold_bad++;
      end
      if (app_wr_cmd && app_wr_rdy) begin
        obs_addr_q.push_back(app_wr_addr);
        obs_data_q.push_back(app_wr_data);
        obs_t_q.push_back($time);
      end
      prev_stall = app_wr_cmd && !app_wr_rdy;
      hold_addr  = app_wr_addr;
      hold_data  = app_wr_data;
    end
  end

  // ---------------- check / driver tasks ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_dout  = fifo_empty ? '0 : fifo_q[0];
  endtask

  // Advance n cycles; the FIFO model and rdy generator update 1 ns after each edge.
  task automatic tick(input int n);
    logic [DW-1:0] tmp;
    repeat (n) begin
      @(posedge clk);
      #1;
      while (pops_done < n_pops) begin
        if (fifo_q.size() != 0) tmp = fifo_q.pop_front();
        pops_done++;
      end
      refresh_fifo();
      if (rdy_mode == 1) app_wr_rdy = 1'($urandom_range(0, 1));
      else if (rdy_mode == 2) begin
        app_wr_rdy = rdy_pat[3 - (pat_idx % 4)];
        pat_idx++;
      end
    end
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    fifo_q.push_back(d);
    exp_q.push_back(d);
    refresh_fifo();
  endtask

  task automatic pulse_start();
    start_store = 1'b1; tick(1); start_store = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_store = 1'b1; tick(1); stop_store = 1'b0;
  endtask

  task automatic wait_fifo_empty(input string tag, input int budget);
    int k = 0;
    while (!fifo_empty && k < budget) begin tick(1); k++; end
    check({tag, "_fifo_drained"}, fifo_empty, 1'b1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (!store_done && k < budget) begin tick(1); k++; end
    check({tag, "_store_done"}, store_done, 1'b1);
  endtask

  // Expected memory image: words leave the FIFO in order and land at consecutive
  // addresses starting from the low address of the record.
  task automatic check_writes(input string tag, input int n_exp);
    int n_new;
    logic [DW-1:0] exp_d;
    n_new = obs_addr_q.size() - rd_ptr;
    check({tag, "_write_count"}, n_new, n_exp);
    for (int i = 0; i < n_new; i++) begin
      if (exp_q.size() != 0) exp_d = exp_q.pop_front();
      else exp_d = 'x;
      check({tag, "_wr_data"}, obs_data_q[rd_ptr], exp_d);
      check({tag, "_wr_addr"}, obs_addr_q[rd_ptr], exp_addr);
      exp_addr++;
      rd_ptr++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd"}, app_wr_cmd, 1'b0);
    check({tag, "_addr"}, app_wr_addr, '0);
    check({tag, "_data"}, app_wr_data, '0);
    check({tag, "_bw"}, app_wr_bw, 4'hf);
    check({tag, "_rd_en"}, fifo_rd_en, 1'b0);
    check({tag, "_busy"}, store_busy, 1'b0);
    check({tag, "_done"}, store_done, 1'b0);
    check({tag, "_mem_high"}, mem_addr_high, 1'b0);
    check({tag, "_q0"}, q0_mem_high, '0);
    check({tag, "_state"}, state_dbg, 3'd0);
`ifdef STORE_WORD_COUNT_EN
    check({tag, "_stored_words"}, stored_words, 32'd0);
`endif
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int first;
    int rem;
    longint dt;

    // reset
    #2;
    check_reset_outputs("por");
    tick(2);
    rst = 1'b1;
    tick(1);

    // basic store: 8 words, back-to-back
    cal_done = 1'b1;
    app_wr_rdy = 1'b1;
    for (int i = 1; i <= 8; i++) push_word(DW'(i));
    exp_addr = 0;
    first = rd_ptr;
    pulse_start();
    check("basic_busy", store_busy, 1'b1);
    wait_fifo_empty("basic", 40);
    pulse_stop();
    wait_done("basic", 40);
    check_writes("basic", 8);
    dt = obs_t_q[rd_ptr - 1] - obs_t_q[first];
    check("basic_back_to_back", dt, 64'd70);
    check("basic_q0", q0_mem_high, 4'd7);
    check("basic_mem_high", mem_addr_high, 1'b0);
    check("basic_busy_end", store_busy, 1'b0);
`ifdef STORE_WORD_COUNT_EN
    check("basic_stored_words", stored_words, 32'd8);
`endif

    // backpressure: rdy follows 1,0,0,1
    rdy_mode = 2;
    pat_idx = 0;
    for (int i = 0; i < 4; i++) push_word(DW'($urandom));
    exp_addr = 0;
    pulse_start();
    wait_fifo_empty("bp", 100);
    pulse_stop();
    wait_done("bp", 100);
    rdy_mode = 0;
    app_wr_rdy = 1'b1;
    check_writes("bp", 4);
    check("bp_q0", q0_mem_high, 4'd3);
    check("bp_stalls_seen", (hold_cnt > 0), 1'b1);
    check("bp_hold_stable", hold_bad, 0);

    // calibration gate
    cal_done = 1'b0;
    for (int i = 0; i < 3; i++) push_word(DW'($urandom));
    exp_addr = 0;
    first = n_pops;
    rem = n_cmd_seen;
    pulse_start();
    tick(50);
    check("cal_no_pop", n_pops - first, 0);
    check("cal_no_cmd", n_cmd_seen - rem, 0);
    check("cal_busy", store_busy, 1'b1);
    check("cal_fifo_kept", fifo_q.size(), 3);
    cal_done = 1'b1;
    wait_fifo_empty("cal", 40);
    pulse_stop();
    wait_done("cal", 40);
    check_writes("cal", 3);
    check("cal_q0", q0_mem_high, 4'd2);

    // address exhaustion with random backpressure
    rdy_mode = 1;
    for (int i = 0; i < 20; i++) push_word(DW'($urandom));
    exp_addr = 0;
    pulse_start();
    wait_done("full", 400);
    rdy_mode = 0;
    app_wr_rdy = 1'b1;
    check_writes("full", 16);
    check("full_mem_high", mem_addr_high, 1'b1);
    check("full_q0", q0_mem_high, 4'd15);
    check("full_fifo_left", fifo_q.size(), 4);
    check("full_exp_left", exp_q.size(), 4);
    check("full_hold_stable", hold_bad, 0);
    fifo_q.delete();
    exp_q.delete();
    refresh_fifo();

    // reset while a command is stalled
    for (int i = 0; i < 6; i++) push_word(DW'($urandom));
    exp_addr = 0;
    first = 0;
    pulse_start();
    while ((obs_addr_q.size() - rd_ptr) < 3 && first < 40) begin tick(1); first++; end
    app_wr_rdy = 1'b0;
    tick(1);
    check("rst_cmd_pending", app_wr_cmd, 1'b1);
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick(1);
    rst = 1'b1;
    check_writes("pre_rst", 3);
    check("rst_fifo_left", fifo_q.size(), 2);
    exp_q = fifo_q;
    rem = fifo_q.size();
    exp_addr = 0;
    app_wr_rdy = 1'b1;
    tick(1);
    pulse_start();
    wait_fifo_empty("post_rst", 40);
    pulse_stop();
    wait_done("post_rst", 40);
    check_writes("post_rst", rem);
    check("post_rst_q0", q0_mem_high, 4'd1);

    // soft reset, then zero-length record (stop before start, empty FIFO)
    sw_rst = 1'b1;
    tick(1);
    sw_rst = 1'b0;
    check_reset_outputs("swrst");
    pulse_stop();
    tick(2);
    exp_addr = 0;
    pulse_start();
    wait_done("zero", 40);
    check_writes("zero", 0);
    check("zero_q0", q0_mem_high, 4'd0);
    check("zero_mem_high", mem_addr_high, 1'b0);
`ifdef STORE_WORD_COUNT_EN
    check("zero_stored_words", stored_words, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
